// File: rtl/escape_sequence_encoder.sv
// VT100 transmit encoder: turns keystrokes, cursor keys and query replies into
// byte streams for the UART TX valid/ready interface, one byte per clock.
module escape_sequence_encoder #(
  parameter bit C1_CONTROLS = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reqValid,
  output logic       reqReady,
  input  logic [2:0] reqType,
  input  logic [7:0] reqPn1,
  input  logic [7:0] reqPn2,
  input  logic       appCursor,
  output logic [7:0] txData,
  output logic       txValid,
  input  logic       txReady,
  output logic       busy
);

  // Handshakes: a request is taken on reqValid && reqReady; a byte moves on
  // txValid && txReady, and txData/txValid hold steady while txReady is low.

  localparam logic [2:0] T_CHAR   = 3'd0;
  localparam logic [2:0] T_CURKEY = 3'd1;
  localparam logic [2:0] T_CPR    = 3'd2;
  localparam logic [2:0] T_DA     = 3'd3;
  localparam logic [2:0] T_DSR    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ESC   = 3'd1,
    S_INTRO = 3'd2,
    S_QMARK = 3'd3,
    S_NUM1  = 3'd4,
    S_SEMI  = 3'd5,
    S_NUM2  = 3'd6,
    S_FINAL = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_type;
  logic [7:0]  r_pn1;
  logic [7:0]  r_pn2;
  logic        r_app;
  logic [1:0]  r_didx;
  logic [1:0]  w_didx_next;

  logic        w_accept;
  logic        w_xfer;
  logic        w_reserved;
  logic        w_ss3;
  logic [7:0]  w_num;
  logic [7:0]  w_q100;
  logic [7:0]  w_q10;
  logic [7:0]  w_tens;
  logic [7:0]  w_ones;
  logic [1:0]  w_ndig;
  logic        w_last_digit;
  logic [7:0]  w_digit;

  assign reqReady   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign w_accept   = reqValid && reqReady;
  assign w_reserved = (r_type > T_DSR);
  assign w_ss3      = (r_type == T_CURKEY) && r_app;
  assign txValid    = (r_state != S_IDLE) && !w_reserved;
  assign w_xfer     = txValid && txReady;

  // Decimal digits of whichever parameter is being emitted, from latched values.
  assign w_num  = (r_state == S_NUM2) ? r_pn2 : r_pn1;
  assign w_q100 = w_num / 8'd100;
  assign w_q10  = w_num / 8'd10;
  assign w_tens = w_q10 % 8'd10;
  assign w_ones = w_num % 8'd10;
  assign w_ndig = (w_num >= 8'd100) ? 2'd3 : ((w_num >= 8'd10) ? 2'd2 : 2'd1);
  assign w_last_digit = (r_didx == (w_ndig - 2'd1));

  always_comb begin
    w_digit = 8'h30 + w_ones;
    case (w_ndig)
      2'd3: begin
        if (r_didx == 2'd0)      w_digit = 8'h30 + w_q100;
        else if (r_didx == 2'd1) w_digit = 8'h30 + w_tens;
      end
      2'd2: begin
        if (r_didx == 2'd0)      w_digit = 8'h30 + w_tens;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_didx  <= 2'd0;
      r_type  <= T_CHAR;
      r_pn1   <= 8'h00;
      r_pn2   <= 8'h00;
      r_app   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_didx  <= w_didx_next;
      if (w_accept) begin
        r_type <= reqType;
        r_app  <= appCursor;
        // DA and DSR reuse the numeric path with fixed parameters "1;0" and "0".
        case (reqType)
          T_DA:    begin r_pn1 <= 8'd1; r_pn2 <= 8'd0;   end
          T_DSR:   begin r_pn1 <= 8'd0; r_pn2 <= 8'd0;   end
          default: begin r_pn1 <= reqPn1; r_pn2 <= reqPn2; end
        endcase
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_didx_next  = r_didx;
    case (r_state)
      S_IDLE: begin
        w_didx_next = 2'd0;
        if (w_accept) begin
          if (reqType == T_CHAR || reqType > T_DSR) w_state_next = S_FINAL;
          else if (C1_CONTROLS)                      w_state_next = S_INTRO;
          else                                        w_state_next = S_ESC;
        end
      end
      S_ESC: if (w_xfer) w_state_next = S_INTRO;
      S_INTRO: begin
        if (w_xfer) begin
          case (r_type)
            T_CURKEY:     w_state_next = S_FINAL;
            T_CPR, T_DSR: w_state_next = S_NUM1;
            T_DA:         w_state_next = S_QMARK;
            default:      w_state_next = S_IDLE;
          endcase
        end
      end
      S_QMARK: if (w_xfer) w_state_next = S_NUM1;
      S_NUM1: begin
        if (w_xfer) begin
          if (w_last_digit) begin
            w_didx_next  = 2'd0;
            w_state_next = (r_type == T_DSR) ? S_FINAL : S_SEMI;
          end else begin
            w_didx_next = r_didx + 2'd1;
          end
        end
      end
      S_SEMI: if (w_xfer) w_state_next = S_NUM2;
      S_NUM2: begin
        if (w_xfer) begin
          if (w_last_digit) begin
            w_didx_next  = 2'd0;
            w_state_next = S_FINAL;
          end else begin
            w_didx_next = r_didx + 2'd1;
          end
        end
      end
      S_FINAL: begin
        // Reserved types sit here silently for one cycle, then release.
        if (w_reserved || w_xfer) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    txData = 8'h00;
    case (r_state)
      S_ESC:   txData = 8'h1b;
      S_INTRO: begin
        if (C1_CONTROLS) txData = w_ss3 ? 8'h8f : 8'h9b;
        else             txData = w_ss3 ? 8'h4f : 8'h5b;
      end
      S_QMARK: txData = 8'h3f;
      S_NUM1:  txData = w_digit;
      S_SEMI:  txData = 8'h3b;
      S_NUM2:  txData = w_digit;
      S_FINAL: begin
        case (r_type)
          T_CHAR, T_CURKEY: txData = r_pn1;
          T_CPR:            txData = 8'h52;
          T_DA:             txData = 8'h63;
          T_DSR:            txData = 8'h6e;
          default:          txData = 8'h00;
        endcase
      end
      default: txData = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_escape_sequence_encoder.sv
// Bench for escape_sequence_encoder: a 7-bit and a C1 instance, table-driven
// sequences plus stall, reset and reserved-type cases, checked by a byte queue.
module tb_escape_sequence_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       req_valid;
  logic [2:0] req_type;
  logic [7:0] req_pn1;
  logic [7:0] req_pn2;
  logic       req_app;
  logic       tx_ready;

  logic       rr0, rr1, tv0, tv1, bz0, bz1;
  logic [7:0] td0, td1;
  logic       req_ready, tx_valid, busy;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  escape_sequence_encoder u_dut0 (
    .clk(clk), .rst(rst), .reqValid(req_valid & ~sel), .reqReady(rr0),
    .reqType(req_type), .reqPn1(req_pn1), .reqPn2(req_pn2), .appCursor(req_app),
    .txData(td0), .txValid(tv0), .txReady(tx_ready), .busy(bz0)
  );

  escape_sequence_encoder #(.C1_CONTROLS(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .reqValid(req_valid & sel), .reqReady(rr1),
    .reqType(req_type), .reqPn1(req_pn1), .reqPn2(req_pn2), .appCursor(req_app),
    .txData(td1), .txValid(tv1), .txReady(tx_ready), .busy(bz1)
  );

  assign req_ready = sel ? rr1 : rr0;
  assign tx_valid  = sel ? tv1 : tv0;
  assign tx_data   = sel ? td1 : td0;
  assign busy      = sel ? bz1 : bz0;

  typedef struct {
    logic [2:0]  t;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic        app;
    int          n;
    logic [63:0] bytes;  // first byte in [63:56]
  } vec_t;

  vec_t       vecs[11];
  logic [7:0] exp_q[$];
  logic [7:0] e_byte;
  int         checks = 0;
  int         errors = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Scoreboard: every transferred byte must match the head of the queue.
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("hold_valid", {31'd0, tx_valid}, 32'd1);
      chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
    end
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_byte: got %0h required none", tx_data);
      end else begin
        e_byte = exp_q.pop_front();
        chk("byte", {24'd0, tx_data}, {24'd0, e_byte});
      end
    end
    prev_stall = tx_valid && !tx_ready && !rst;
    prev_data  = tx_data;
  end

  task automatic push_bytes(input logic [63:0] b, input int n);
    for (int j = 0; j < n; j++) exp_q.push_back(b[63-8*j -: 8]);
  endtask

  task automatic send(input logic s, input logic [2:0] t, input logic [7:0] p1,
                      input logic [7:0] p2, input logic app);
    int w;
    w = 0;
    sel = s;
    #1;
    while (!req_ready && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got reqReady 0 required 1");
    end
    req_type  = t;
    req_pn1   = p1;
    req_pn2   = p2;
    req_app   = app;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the latched request must be unaffected.
    req_valid = 1'b0;
    req_app   = ~app;
    req_pn1   = 8'($urandom_range(0, 255));
    req_pn2   = 8'($urandom_range(0, 255));
    req_type  = 3'($urandom_range(0, 7));
  endtask

  task automatic expect_stream(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("stream_valid", {31'd0, tx_valid}, 32'd1);
    end
    @(negedge clk);
    chk("ready_after", {31'd0, req_ready}, 32'd1);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("valid_after", {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || !req_ready) && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
    chk("drain_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int w;
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_type = 3'd0;
    req_pn1 = 8'h00; req_pn2 = 8'h00; req_app = 1'b0; tx_ready = 1'b1;

    vecs[0]  = '{3'd2, 8'd12,  8'd80,  1'b0, 8, 64'h1b5b31323b383052};
    vecs[1]  = '{3'd2, 8'd255, 8'd0,   1'b0, 8, 64'h1b5b3235353b3052};
    vecs[2]  = '{3'd1, 8'h41,  8'h00,  1'b0, 3, 64'h1b5b410000000000};
    vecs[3]  = '{3'd1, 8'h41,  8'h00,  1'b1, 3, 64'h1b4f410000000000};
    vecs[4]  = '{3'd3, 8'h55,  8'h66,  1'b0, 7, 64'h1b5b3f313b306300};
    vecs[5]  = '{3'd4, 8'h99,  8'h12,  1'b1, 4, 64'h1b5b306e00000000};
    vecs[6]  = '{3'd0, 8'h41,  8'h00,  1'b1, 1, 64'h4100000000000000};
    vecs[7]  = '{3'd2, 8'd0,   8'd5,   1'b0, 6, 64'h1b5b303b35520000};
    vecs[8]  = '{3'd2, 8'd7,   8'd100, 1'b1, 8, 64'h1b5b373b31303052};
    vecs[9]  = '{3'd1, 8'h44,  8'h00,  1'b1, 3, 64'h1b4f440000000000};
    vecs[10] = '{3'd0, 8'h00,  8'hff,  1'b0, 1, 64'h0000000000000000};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, rr0}, 32'd1);
    chk("rst_busy", {31'd0, bz0}, 32'd0);
    chk("rst_valid", {31'd0, tv0}, 32'd0);
    chk("rst_data", {24'd0, td0}, 32'd0);
    chk("rst_ready_c1", {31'd0, rr1}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      push_bytes(vecs[i].bytes, vecs[i].n);
      send(1'b0, vecs[i].t, vecs[i].p1, vecs[i].p2, vecs[i].app);
      expect_stream(vecs[i].n);
    end

    // DA with the '?' byte stalled for three cycles.
    push_bytes(64'h1b5b3f313b306300, 7);
    send(1'b0, 3'd3, 8'h00, 8'h00, 1'b0);
    w = 0;
    while (!(tx_valid && tx_data == 8'h3f) && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("stall_found", {24'd0, tx_data}, 32'h3f);
    tx_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_data", {24'd0, tx_data}, 32'h3f);
      chk("stall_valid", {31'd0, tx_valid}, 32'd1);
      @(posedge clk);
    end
    #1 tx_ready = 1'b1;
    wait_idle();

    // Reset during the third CPR byte abandons the sequence.
    push_bytes(64'h1b5b31323b383052, 8);
    send(1'b0, 3'd2, 8'd12, 8'd80, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_data", {24'd0, tx_data}, 32'h31);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("post_rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    push_bytes(64'h4100000000000000, 1);
    send(1'b0, 3'd0, 8'h41, 8'h00, 1'b0);
    expect_stream(1);

    // C1 introducers.
    push_bytes(64'h9b306e0000000000, 3);
    send(1'b1, 3'd4, 8'h00, 8'h00, 1'b0);
    expect_stream(3);
    push_bytes(64'h8f41000000000000, 2);
    send(1'b1, 3'd1, 8'h41, 8'h00, 1'b1);
    expect_stream(2);
    push_bytes(64'h9b3235353b310000, 6);
    exp_q.push_back(8'h52);
    send(1'b1, 3'd2, 8'd255, 8'd1, 1'b0);
    expect_stream(7);

    // Reserved types on both instances: silent, one busy cycle.
    for (int s = 0; s < 2; s++) begin
      send(s[0], (s == 0) ? 3'd7 : 3'd6, 8'h41, 8'h42, 1'b0);
      @(negedge clk);
      chk("rsv_valid", {31'd0, tx_valid}, 32'd0);
      chk("rsv_ready_low", {31'd0, req_ready}, 32'd0);
      chk("rsv_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("rsv_ready_back", {31'd0, req_ready}, 32'd1);
      chk("rsv_valid2", {31'd0, tx_valid}, 32'd0);
    end

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running required finished");
    $fatal(1, "simulation time limit");
  end

endmodule
